// File: rtl/des_dec_key_sched.sv
// DES decryption key scheduler: PC-1 on load, then K16..K1 one per valid/ready
// transfer by right-rotating the C/D halves and applying PC-2.
module des_dec_key_sched #(
    parameter bit PARITY_CHECK = 1'b0
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [0:63] KEY_IN,
    input  logic        KEY_LOAD,
    output logic [0:47] SUBKEY,
    output logic [4:0]  ROUND,
    output logic        SUBKEY_VALID,
    input  logic        SUBKEY_READY,
    output logic        BUSY,
    output logic        DONE,
    output logic        KEY_ERR
);

    localparam int unsigned CD_W       = 28;
    localparam int unsigned SK_W       = 48;
    localparam int unsigned NUM_ROUNDS = 16;
    localparam logic [3:0]  LAST_IDX   = 4'(NUM_ROUNDS - 1);

    // FIPS 46-3 tables, 1-based bit positions with bit 1 = MSB
    localparam int unsigned PC1 [2*CD_W] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    localparam int unsigned PC2 [SK_W] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [0:CD_W-1]   c_q, c_d;
    logic [0:CD_W-1]   d_q, d_d;
    logic [3:0]        idx_q, idx_d;
    logic [4:0]        round_q, round_d;
    logic              done_q, done_d;
    logic              key_err_q, key_err_d;

    logic [0:2*CD_W-1] pc1_out;
    logic [0:2*CD_W-1] cd_cat;
    logic [7:0]        byte_odd;
    logic              key_par_bad;
    logic              single_shift;
    logic [0:CD_W-1]   c_rot1, c_rot2, d_rot1, d_rot2;

    // Key permutation into C/D
    for (genvar g = 0; g < 2*CD_W; g++) begin : g_pc1
        assign pc1_out[g] = KEY_IN[6'(PC1[g] - 1)];
    end

    // Each key byte must carry odd parity when checking is enabled
    for (genvar g = 0; g < 8; g++) begin : g_par
        assign byte_odd[g] = ^KEY_IN[8*g +: 8];
    end
    assign key_par_bad = ~&byte_odd;

    // Subkey is always PC-2 of the registered halves
    assign cd_cat = {c_q, d_q};
    for (genvar g = 0; g < SK_W; g++) begin : g_pc2
        assign SUBKEY[g] = cd_cat[6'(PC2[g] - 1)];
    end

    // Undoing the encryption left shifts: single steps before K15, K8 and K1
    assign single_shift = (idx_q == 4'd0) || (idx_q == 4'd7) || (idx_q == 4'd14);
    assign c_rot1 = {c_q[CD_W-1], c_q[0:CD_W-2]};
    assign c_rot2 = {c_q[CD_W-2:CD_W-1], c_q[0:CD_W-3]};
    assign d_rot1 = {d_q[CD_W-1], d_q[0:CD_W-2]};
    assign d_rot2 = {d_q[CD_W-2:CD_W-1], d_q[0:CD_W-3]};

    // Next-state and next-output logic
    always_comb begin
        state_d   = state_q;
        c_d       = c_q;
        d_d       = d_q;
        idx_d     = idx_q;
        round_d   = round_q;
        done_d    = 1'b0;
        key_err_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (KEY_LOAD) begin
                    if (PARITY_CHECK && key_par_bad) begin
                        key_err_d = 1'b1;
                    end else begin
                        c_d     = pc1_out[0:CD_W-1];
                        d_d     = pc1_out[CD_W:2*CD_W-1];
                        idx_d   = '0;
                        round_d = 5'(NUM_ROUNDS);
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (SUBKEY_READY) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = IDLE;
                        round_d = '0;
                        done_d  = 1'b1;
                    end else begin
                        c_d     = single_shift ? c_rot1 : c_rot2;
                        d_d     = single_shift ? d_rot1 : d_rot2;
                        idx_d   = 4'(idx_q + 4'd1);
                        round_d = 5'(round_q - 5'd1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= IDLE;
            c_q       <= '0;
            d_q       <= '0;
            idx_q     <= '0;
            round_q   <= '0;
            done_q    <= 1'b0;
            key_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            c_q       <= c_d;
            d_q       <= d_d;
            idx_q     <= idx_d;
            round_q   <= round_d;
            done_q    <= done_d;
            key_err_q <= key_err_d;
        end
    end

    assign ROUND        = round_q;
    assign SUBKEY_VALID = (state_q == RUN);
    assign BUSY         = (state_q == RUN);
    assign DONE         = done_q;
    assign KEY_ERR      = key_err_q;

endmodule

// File: tb/tb_des_dec_key_sched.sv
// Bench for des_dec_key_sched: known-answer table, random keys/backpressure
// against an encryption-order schedule model, plus load/parity/reset corners.
module tb_des_dec_key_sched;

    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
    localparam int LS_T [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
    localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] key_in;
    logic        key_load0, key_load1, ready;
    logic [47:0] sk0, sk1;
    logic [4:0]  rnd0, rnd1;
    logic        v0, v1, b0, b1, d0, d1, e0, e1;

    logic        sel;
    logic [47:0] o_sk;
    logic [4:0]  o_round;
    logic        o_valid, o_busy, o_done, o_err;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [63:0] key;
        logic [4:0]  round;
        logic [47:0] sk;
    } vec_t;
    vec_t vecs [5];

    des_dec_key_sched #(.PARITY_CHECK(1'b0)) dut0 (
        .CLK(clk), .RST_N(rst_n), .KEY_IN(key_in), .KEY_LOAD(key_load0),
        .SUBKEY(sk0), .ROUND(rnd0), .SUBKEY_VALID(v0), .SUBKEY_READY(ready),
        .BUSY(b0), .DONE(d0), .KEY_ERR(e0));

    des_dec_key_sched #(.PARITY_CHECK(1'b1)) dut1 (
        .CLK(clk), .RST_N(rst_n), .KEY_IN(key_in), .KEY_LOAD(key_load1),
        .SUBKEY(sk1), .ROUND(rnd1), .SUBKEY_VALID(v1), .SUBKEY_READY(ready),
        .BUSY(b1), .DONE(d1), .KEY_ERR(e1));

    always #5 clk = ~clk;

    always_comb begin
        o_sk    = sel ? sk1  : sk0;
        o_round = sel ? rnd1 : rnd0;
        o_valid = sel ? v1   : v0;
        o_busy  = sel ? b1   : b0;
        o_done  = sel ? d1   : d0;
        o_err   = sel ? e1   : e0;
    end

    // Encryption-order schedule: K_r after r cumulative left shifts of PC-1
    function automatic logic [47:0] model_sk(input logic [63:0] key, input int r);
        logic [27:0] c, d;
        logic [55:0] cd;
        logic [47:0] k;
        for (int j = 0; j < 28; j++) begin
            c[5'(27 - j)] = key[6'(64 - PC1_T[j])];
            d[5'(27 - j)] = key[6'(64 - PC1_T[j + 28])];
        end
        for (int i = 1; i <= r; i++) begin
            c = (c << LS_T[i-1]) | (c >> (28 - LS_T[i-1]));
            d = (d << LS_T[i-1]) | (d >> (28 - LS_T[i-1]));
        end
        cd = {c, d};
        for (int i = 0; i < 48; i++) k[6'(47 - i)] = cd[6'(56 - PC2_T[i])];
        return k;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_load(input logic v);
        if (sel) key_load1 = v;
        else     key_load0 = v;
    endtask

    task automatic load(input logic [63:0] key);
        key_in = key;
        set_load(1'b1);
        step();
        set_load(1'b0);
    endtask

    // Consume a started sequence; returns in the cycle DONE should be high
    task automatic drain(input logic [63:0] key, input bit rnd_rdy,
                         input int inj_round, input logic [63:0] inj_key);
        int exp_r = 16;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (exp_r == 0) begin
                chk("done_pulse", 64'(o_done), 64'd1);
                chk("valid_after_k1", 64'(o_valid), 64'd0);
                chk("round_after_k1", 64'(o_round), 64'd0);
                return;
            end
            chk("valid", 64'(o_valid), 64'd1);
            chk("busy", 64'(o_busy), 64'd1);
            chk("round", 64'(o_round), 64'(exp_r));
            chk("subkey", 64'(o_sk), 64'(model_sk(key, exp_r)));
            chk("done_early", 64'(o_done), 64'd0);
            if (inj_round != 0 && exp_r == inj_round) begin
                key_in = inj_key;
                set_load(1'b1);
            end
            ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            if (ready) exp_r--;
            step();
        end
        chk("drain_timeout", 64'd0, 64'd1);
    endtask

    task automatic run_key(input logic [63:0] key, input bit rnd_rdy);
        load(key);
        drain(key, rnd_rdy, 0, 64'd0);
        step();
        chk("done_one_cycle", 64'(o_done), 64'd0);
        chk("idle_valid", 64'(o_valid), 64'd0);
    endtask

    initial begin
        bit found;
        logic [63:0] kb;
        sel = 1'b0;
        rst_n = 1'b0;
        key_in = '0;
        key_load0 = 1'b0;
        key_load1 = 1'b0;
        ready = 1'b0;

        vecs[0] = '{KEY_A, 5'd16, 48'hCB3D8B0E17F5};
        vecs[1] = '{KEY_A, 5'd15, 48'hBF918D3D3F0A};
        vecs[2] = '{KEY_A, 5'd3,  48'h55FC8A42CF99};
        vecs[3] = '{KEY_A, 5'd2,  48'h79AED9DBC9E5};
        vecs[4] = '{KEY_A, 5'd1,  48'h1B02EFFC7072};

        // Reset held with inputs toggling
        for (int i = 0; i < 4; i++) begin
            key_in = {$urandom, $urandom};
            key_load0 = 1'b1;
            key_load1 = 1'b1;
            ready = 1'($urandom_range(0, 1));
            step();
            chk("rst_outs0", 64'({sk0, rnd0, v0, b0, d0, e0}), 64'd0);
            chk("rst_outs1", 64'({sk1, rnd1, v1, b1, d1, e1}), 64'd0);
        end
        key_load0 = 1'b0;
        key_load1 = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("idle_no_valid", 64'({v0, v1, b0, b1}), 64'd0);
        end

        // Known-answer table
        for (int i = 0; i < 5; i++) begin
            sel = 1'b0;
            ready = 1'b1;
            load(vecs[i].key);
            found = 1'b0;
            for (int c = 0; c < 20 && !found; c++) begin
                if (o_valid && o_round == vecs[i].round) found = 1'b1;
                else step();
            end
            chk("kat_subkey", 64'(o_sk), 64'(vecs[i].sk));
            for (int c = 0; c < 20 && !o_done; c++) step();
            chk("kat_done", 64'(o_done), 64'd1);
            step();
        end

        // Full sequence with ready high, then with backpressure
        run_key(KEY_A, 1'b0);
        run_key(KEY_A, 1'b1);
        for (int i = 0; i < 4; i++) run_key({$urandom, $urandom}, 1'b1);

        // Load during RUN ignored; accepted in the DONE cycle
        kb = 64'h0E329232EA6D0D73;
        ready = 1'b1;
        load(KEY_A);
        drain(KEY_A, 1'b0, 10, kb);
        step();
        set_load(1'b0);
        chk("reload_done_low", 64'(o_done), 64'd0);
        drain(kb, 1'b0, 0, 64'd0);
        step();

        // Parity checking instance
        sel = 1'b1;
        load(64'h133457799BBCDFF0);
        chk("par_err", 64'(o_err), 64'd1);
        chk("par_no_valid", 64'(o_valid), 64'd0);
        step();
        chk("par_err_pulse", 64'(o_err), 64'd0);
        load(64'h123457799BBCDFF1);
        chk("par_err_b0", 64'({o_err, o_valid, o_done}), 64'b100);
        step();
        run_key(KEY_A, 1'b0);
        chk("par_good_no_err", 64'(o_err), 64'd0);

        // Without parity checking the even-parity key runs normally
        sel = 1'b0;
        load(64'h133457799BBCDFF0);
        chk("nopar_no_err", 64'(o_err), 64'd0);
        drain(64'h133457799BBCDFF0, 1'b0, 0, 64'd0);
        step();

        // Reset mid-sequence at round 8
        ready = 1'b1;
        load(KEY_A);
        for (int i = 0; i < 8; i++) step();
        chk("mid_round8", 64'(o_round), 64'd8);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_outs", 64'({sk0, rnd0, v0, b0, d0, e0}), 64'd0);
        step();
        chk("mid_rst_no_done", 64'(o_done), 64'd0);
        rst_n = 1'b1;
        step();
        chk("post_rst_idle", 64'({o_done, o_valid}), 64'd0);
        run_key(KEY_A, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

endmodule
